// File: rtl/stream_compressor.sv
// Word-level stream compressor: tags each word as zero / repeat / raw and
// repacks the raw words into dense output beats, one frame at a time.
module stream_compressor #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_DATA        = 8,
  parameter int TAG_WIDTH       = 2,
  parameter int FIFO_ADDR_WIDTH = 4,
  localparam int CNT_WIDTH      = $clog2(NUM_DATA) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [DATA_WIDTH*NUM_DATA-1:0]  i_in_data,
  input  logic                            i_in_last,
  output logic [FIFO_ADDR_WIDTH:0]        o_in_count,
  output logic                            o_tag_valid,
  input  logic                            i_tag_ready,
  output logic [TAG_WIDTH*NUM_DATA-1:0]   o_tag_data,
  output logic [CNT_WIDTH-1:0]            o_tag_len,
  output logic                            o_tag_last,
  output logic                            o_dout_valid,
  input  logic                            i_dout_ready,
  output logic [DATA_WIDTH*NUM_DATA-1:0]  o_dout_data,
  output logic [CNT_WIDTH-1:0]            o_dout_len,
  output logic                            o_dout_last
);

  localparam int DEPTH     = 2 ** FIFO_ADDR_WIDTH;
  localparam int ACC_WORDS = 2 * NUM_DATA;
  localparam int BEAT_W    = DATA_WIDTH * NUM_DATA;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_DATA);

  typedef enum logic [1:0] {
    TAG_ZERO     = 2'b00,
    TAG_REPEAT   = 2'b01,
    TAG_RESERVED = 2'b10,
    TAG_RAW      = 2'b11
  } tagCode_t;

  logic [BEAT_W:0]            r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0]   r_wrPtr;
  logic [FIFO_ADDR_WIDTH:0]   r_rdPtr;
  logic [FIFO_ADDR_WIDTH:0]   w_count;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [BEAT_W:0]            w_head;
  logic [BEAT_W-1:0]          w_headData;
  logic                       w_headLast;

  logic [DATA_WIDTH-1:0]      w_word    [NUM_DATA];
  logic [DATA_WIDTH-1:0]      w_payWord [NUM_DATA];
  logic [TAG_WIDTH*NUM_DATA-1:0] w_tagData;
  logic [CNT_WIDTH-1:0]       w_rawCnt;
  logic [DATA_WIDTH-1:0]      w_prevLane;

  logic                       r_slotFull;
  logic [DATA_WIDTH-1:0]      r_slotWord [NUM_DATA];
  logic [TAG_WIDTH*NUM_DATA-1:0] r_tagData;
  logic [CNT_WIDTH-1:0]       r_tagLen;
  logic                       r_tagLast;
  logic [DATA_WIDTH-1:0]      r_prevWord;

  logic [DATA_WIDTH-1:0]      r_acc [ACC_WORDS];
  logic [CNT_WIDTH-1:0]       r_accCnt;
  logic [CNT_WIDTH-1:0]       w_sumCnt;
  logic                       r_flushPend;
  logic                       r_lastOnFull;
  logic                       w_emitFull;
  logic                       w_tagFire;
  logic                       w_doutFire;

  assign w_count    = r_wrPtr - r_rdPtr;
  assign w_full     = w_count[FIFO_ADDR_WIDTH];
  assign w_empty    = (w_count == '0);
  assign w_push     = i_in_valid && !w_full;
  assign w_pop      = !w_empty && (!r_slotFull || w_tagFire);
  assign w_head     = r_mem[r_rdPtr[FIFO_ADDR_WIDTH-1:0]];
  assign w_headData = w_head[BEAT_W-1:0];
  assign w_headLast = w_head[BEAT_W];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[FIFO_ADDR_WIDTH-1:0]] <= {i_in_last, i_in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DATA; g++) begin : g_lanes
    assign w_word[g] = w_headData[g*DATA_WIDTH +: DATA_WIDTH];
    assign o_dout_data[g*DATA_WIDTH +: DATA_WIDTH] = r_acc[g];
  end

  // Zero beats repeat; raw words are compacted toward lane 0 in arrival order.
  always_comb begin
    w_tagData  = '0;
    w_rawCnt   = '0;
    w_prevLane = r_prevWord;
    for (int i = 0; i < NUM_DATA; i++) begin
      w_payWord[i] = '0;
    end
    for (int i = 0; i < NUM_DATA; i++) begin
      if (w_word[i] == '0) begin
        w_tagData[i*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(TAG_ZERO);
      end else if (w_word[i] == w_prevLane) begin
        w_tagData[i*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(TAG_REPEAT);
      end else begin
        w_tagData[i*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(TAG_RAW);
        w_payWord[w_rawCnt[CNT_WIDTH-2:0]] = w_word[i];
        w_rawCnt = w_rawCnt + CNT_WIDTH'(1);
      end
      w_prevLane = w_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slotFull <= 1'b0;
      r_tagData  <= '0;
      r_tagLen   <= '0;
      r_tagLast  <= 1'b0;
      r_prevWord <= '0;
      for (int i = 0; i < NUM_DATA; i++) begin
        r_slotWord[i] <= '0;
      end
    end else if (w_pop) begin
      r_slotFull <= 1'b1;
      r_tagData  <= w_tagData;
      r_tagLen   <= w_rawCnt;
      r_tagLast  <= w_headLast;
      r_prevWord <= w_headLast ? '0 : w_word[NUM_DATA-1];
      for (int i = 0; i < NUM_DATA; i++) begin
        r_slotWord[i] <= w_payWord[i];
      end
    end else if (w_tagFire) begin
      r_slotFull <= 1'b0;
    end
  end

  assign w_emitFull = (r_accCnt >= FULL_CNT);
  assign w_sumCnt   = r_accCnt + r_tagLen;
  assign w_tagFire  = o_tag_valid && i_tag_ready;
  assign w_doutFire = o_dout_valid && i_dout_ready;

  // Absorb and emit never coincide: a block is only accepted while the
  // accumulator holds less than a beat and no flush is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_accCnt     <= '0;
      r_flushPend  <= 1'b0;
      r_lastOnFull <= 1'b0;
      for (int k = 0; k < ACC_WORDS; k++) begin
        r_acc[k] <= '0;
      end
    end else if (w_doutFire) begin
      for (int k = 0; k < NUM_DATA; k++) begin
        r_acc[k] <= r_acc[k+NUM_DATA];
      end
      for (int k = NUM_DATA; k < ACC_WORDS; k++) begin
        r_acc[k] <= '0;
      end
      if (w_emitFull) begin
        r_accCnt     <= r_accCnt - FULL_CNT;
        r_lastOnFull <= 1'b0;
      end else begin
        r_accCnt    <= '0;
        r_flushPend <= 1'b0;
      end
    end else if (w_tagFire) begin
      for (int j = 0; j < NUM_DATA; j++) begin
        if (CNT_WIDTH'(j) < r_tagLen) begin
          r_acc[r_accCnt + CNT_WIDTH'(j)] <= r_slotWord[j];
        end
      end
      r_accCnt <= w_sumCnt;
      if (r_tagLast) begin
        if (w_sumCnt == FULL_CNT) r_lastOnFull <= 1'b1;
        else                      r_flushPend  <= 1'b1;
      end
    end
  end

  assign o_in_ready   = !w_full;
  assign o_in_count   = w_count;
  assign o_tag_valid  = r_slotFull && (r_accCnt < FULL_CNT) && !r_flushPend;
  assign o_tag_data   = r_tagData;
  assign o_tag_len    = r_tagLen;
  assign o_tag_last   = r_tagLast;
  assign o_dout_valid = w_emitFull || r_flushPend;
  assign o_dout_len   = w_emitFull ? FULL_CNT : (r_flushPend ? r_accCnt : '0);
  assign o_dout_last  = w_emitFull ? r_lastOnFull : r_flushPend;

endmodule

// File: tb/tb_stream_compressor.sv
// Bench for stream_compressor: directed scenarios plus random frames, checked
// against a frame-level reference model of tags and packed output beats.
module tb_stream_compressor;

  localparam int DW  = 32;
  localparam int N   = 8;
  localparam int TW  = 2;
  localparam int FAW = 4;
  localparam int CW  = 4;
  localparam int BW  = DW * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [BW-1:0] i_in_data = '0;
  logic          i_in_last = 1'b0;
  logic [FAW:0]  o_in_count;
  logic          o_tag_valid;
  logic          i_tag_ready = 1'b0;
  logic [TW*N-1:0] o_tag_data;
  logic [CW-1:0] o_tag_len;
  logic          o_tag_last;
  logic          o_dout_valid;
  logic          i_dout_ready = 1'b0;
  logic [BW-1:0] o_dout_data;
  logic [CW-1:0] o_dout_len;
  logic          o_dout_last;

  stream_compressor #(
    .DATA_WIDTH(DW), .NUM_DATA(N), .TAG_WIDTH(TW), .FIFO_ADDR_WIDTH(FAW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_in_last(i_in_last), .o_in_count(o_in_count),
    .o_tag_valid(o_tag_valid), .i_tag_ready(i_tag_ready), .o_tag_data(o_tag_data),
    .o_tag_len(o_tag_len), .o_tag_last(o_tag_last),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_dout_data(o_dout_data),
    .o_dout_len(o_dout_len), .o_dout_last(o_dout_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [TW*N-1:0] tags; int len; logic last; } tagBeat_t;
  typedef struct { logic [BW-1:0] data; int len; logic last; } doutBeat_t;

  tagBeat_t      expTag[$];
  doutBeat_t     expDout[$];
  doutBeat_t     obsDout[$];
  logic [DW-1:0] mFrame[$];
  logic [DW-1:0] mPrev = '0;
  logic [DW-1:0] genLast = '0;
  int compared = 0;
  int mismatched = 0;
  int acceptedCount = 0;

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference model: tags follow the zero/repeat/raw rules word by word; output
  // beats are cut from the frame's raw-word list once the frame is complete.
  task automatic modelPush(input logic [BW-1:0] d, input logic l);
    tagBeat_t t;
    doutBeat_t ob;
    logic [DW-1:0] w, p;
    int len, total, nFull, rem, c;
    len = 0;
    t.tags = '0;
    p = mPrev;
    for (int i = 0; i < N; i++) begin
      w = d[i*DW +: DW];
      if (w == '0) t.tags[i*TW +: TW] = 2'b00;
      else if (w == p) t.tags[i*TW +: TW] = 2'b01;
      else begin
        t.tags[i*TW +: TW] = 2'b11;
        mFrame.push_back(w);
        len++;
      end
      p = w;
    end
    t.len = len;
    t.last = l;
    expTag.push_back(t);
    mPrev = l ? '0 : d[(N-1)*DW +: DW];
    if (l) begin
      total = mFrame.size();
      nFull = total / N;
      rem = total % N;
      c = ((total - len) % N) + len;
      for (int b = 0; b < nFull; b++) begin
        ob.data = '0;
        for (int k = 0; k < N; k++) ob.data[k*DW +: DW] = mFrame[b*N + k];
        ob.len = N;
        ob.last = (b == nFull - 1) && (rem == 0) && (c == N);
        expDout.push_back(ob);
      end
      if (rem != 0) begin
        ob.data = '0;
        for (int k = 0; k < rem; k++) ob.data[k*DW +: DW] = mFrame[nFull*N + k];
        ob.len = rem;
        ob.last = 1'b1;
        expDout.push_back(ob);
      end else if (c != N) begin
        ob.data = '0;
        ob.len = 0;
        ob.last = 1'b1;
        expDout.push_back(ob);
      end
      mFrame.delete();
    end
  endtask

  task automatic clearModel();
    expTag.delete();
    expDout.delete();
    obsDout.delete();
    mFrame.delete();
    mPrev = '0;
    genLast = '0;
  endtask

  // One clock cycle: drive inputs, observe handshakes at the negedge.
  task automatic applyStimulus(input logic v, input logic [BW-1:0] d, input logic l,
                               input logic tr, input logic dr);
    tagBeat_t t;
    doutBeat_t ob;
    i_in_valid = v;
    i_in_data = d;
    i_in_last = l;
    i_tag_ready = tr;
    i_dout_ready = dr;
    @(negedge clk);
    if (o_tag_valid && i_tag_ready) begin
      if (expTag.size() == 0) checkOutput("tagUnexpected", 256'(1), 256'(0));
      else begin
        t = expTag.pop_front();
        checkOutput("tagData", 256'(o_tag_data), 256'(t.tags));
        checkOutput("tagLen", 256'(o_tag_len), 256'(t.len));
        checkOutput("tagLast", 256'(o_tag_last), 256'(t.last));
      end
    end
    if (o_dout_valid && i_dout_ready) begin
      ob.data = o_dout_data;
      ob.len = int'(o_dout_len);
      ob.last = o_dout_last;
      obsDout.push_back(ob);
    end
    if (i_in_valid && o_in_ready) begin
      modelPush(d, l);
      acceptedCount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input logic [BW-1:0] d, input logic l, input logic tr,
                          input logic dr, input logic rnd);
    int start;
    start = acceptedCount;
    for (int c = 0; c < 200 && acceptedCount == start; c++) begin
      if (rnd) applyStimulus($urandom_range(0, 3) != 0, d, l,
                             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      else     applyStimulus(1'b1, d, l, tr, dr);
    end
    if (acceptedCount == start) checkOutput("pushTimeout", 256'(0), 256'(1));
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int c = 0; c < 400 && !idle; c++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle = (expTag.size() == 0) && !o_dout_valid && !o_tag_valid && (o_in_count == '0);
    end
    checkOutput("drainIdle", 256'(idle), 256'(1));
  endtask

  task automatic verifyDout();
    int n;
    checkOutput("doutCount", 256'(obsDout.size()), 256'(expDout.size()));
    n = (obsDout.size() < expDout.size()) ? obsDout.size() : expDout.size();
    for (int k = 0; k < n; k++) begin
      checkOutput("doutData", 256'(obsDout[k].data), 256'(expDout[k].data));
      checkOutput("doutLen", 256'(obsDout[k].len), 256'(expDout[k].len));
      checkOutput("doutLast", 256'(obsDout[k].last), 256'(expDout[k].last));
    end
    obsDout.delete();
    expDout.delete();
  endtask

  task automatic resetDut();
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_in_last = 1'b0;
    i_tag_ready = 1'b0;
    i_dout_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rstInReady", 256'(o_in_ready), 256'(1));
    checkOutput("rstInCount", 256'(o_in_count), 256'(0));
    checkOutput("rstTagValid", 256'(o_tag_valid), 256'(0));
    checkOutput("rstDoutValid", 256'(o_dout_valid), 256'(0));
    checkOutput("rstTagOut", 256'({o_tag_data, o_tag_len, o_tag_last}), 256'(0));
    checkOutput("rstDoutOut", 256'({o_dout_data, o_dout_len, o_dout_last}), 256'(0));
  endtask

  function automatic logic [BW-1:0] mkBeat(input int base);
    logic [BW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(base + i + 1);
    return d;
  endfunction

  function automatic logic [BW-1:0] randBeat();
    logic [BW-1:0] d;
    logic [DW-1:0] p, w;
    p = genLast;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       w = '0;
        1:       w = p;
        2:       w = $urandom;
        default: w = DW'($urandom_range(1, 6));
      endcase
      d[i*DW +: DW] = w;
      p = w;
    end
    genLast = p;
    return d;
  endfunction

  // Known beat with hand-derived tags and packed output, including latency.
  task automatic beatKnown();
    int lanes[8] = '{0, 0, 5, 5, 7, 0, 7, 7};
    logic [BW-1:0] d, e;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(lanes[i]);
    e = '0;
    e[31:0] = 32'd5;
    e[63:32] = 32'd7;
    e[95:64] = 32'd7;
    applyStimulus(1'b1, d, 1'b1, 1'b1, 1'b1);
    checkOutput("latTagEarly", 256'(o_tag_valid), 256'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("latTagValid", 256'(o_tag_valid), 256'(1));
    checkOutput("knownTagData", 256'(o_tag_data), 256'(16'h7370));
    checkOutput("knownTagLen", 256'(o_tag_len), 256'(3));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("knownDoutValid", 256'(o_dout_valid), 256'(1));
    checkOutput("knownDoutData", 256'(o_dout_data), 256'(e));
    checkOutput("knownDoutLen", 256'(o_dout_len), 256'(3));
    checkOutput("knownDoutLast", 256'(o_dout_last), 256'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("knownDoutDone", 256'(o_dout_valid), 256'(0));
  endtask

  initial begin
    int base;
    resetDut();
    clearModel();

    beatKnown();

    // All-zero single-beat frame
    applyStimulus(1'b1, '0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("zeroTagLen", 256'(o_tag_len), 256'(0));
    checkOutput("zeroTagLast", 256'(o_tag_last), 256'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("zeroDoutValid", 256'(o_dout_valid), 256'(1));
    checkOutput("zeroDoutLen", 256'(o_dout_len), 256'(0));
    checkOutput("zeroDoutLast", 256'(o_dout_last), 256'(1));
    drain();
    verifyDout();

    // Three full beats, then a frame starting with the previous frame's last word
    pushBeat(mkBeat(16), 1'b0, 1'b1, 1'b1, 1'b0);
    pushBeat(mkBeat(32), 1'b0, 1'b1, 1'b1, 1'b0);
    pushBeat(mkBeat(48), 1'b1, 1'b1, 1'b1, 1'b0);
    begin
      logic [BW-1:0] d;
      d = mkBeat(96);
      d[DW-1:0] = DW'(48 + N);
      pushBeat(d, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    drain();
    verifyDout();

    // Output stalled: FIFO plus slot plus one absorbed beat fill up
    base = acceptedCount;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, mkBeat(200 + (acceptedCount - base) * 16),
                    (acceptedCount - base) == 19, 1'b1, 1'b0);
    end
    checkOutput("stallAccepted", 256'(acceptedCount - base), 256'(18));
    checkOutput("stallCount", 256'(o_in_count), 256'(16));
    checkOutput("stallInReady", 256'(o_in_ready), 256'(0));
    while (acceptedCount - base < 20) begin
      pushBeat(mkBeat(200 + (acceptedCount - base) * 16), (acceptedCount - base) == 19,
               1'b1, 1'b1, 1'b0);
    end
    drain();
    verifyDout();

    // Reset with a partial accumulator and a loaded FIFO
    begin
      logic [BW-1:0] d;
      d = '0;
      for (int i = 0; i < 5; i++) d[i*DW +: DW] = DW'(i + 1);
      pushBeat(d, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 4; b++) pushBeat(mkBeat(600 + b * 16), 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("preResetCount", 256'(o_in_count), 256'(3));
      checkOutput("preResetDout", 256'(o_dout_valid), 256'(0));
    end
    resetDut();
    clearModel();
    beatKnown();
    drain();
    verifyDout();

    // Random frames with random stalls on every interface
    for (int f = 0; f < 60; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) pushBeat(randBeat(), b == nb - 1, 1'b1, 1'b1, 1'b1);
    end
    drain();
    verifyDout();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
